// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the iterative multiply/divide unit: default widths,
// operation encodings and control state encodings.
package mult_div_unit_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int CNT_WIDTH_DEF  = 5;

    // op[1] selects divide, op[0] selects signed operation.
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_t;

endpackage

// File: rtl/mult_div_unit_dffr_32.sv
// Register with asynchronous active-high reset and load enable. Used for the
// architectural HI/LO registers and for the operand latches.
module dffr_32 #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Load on enable, clear immediately on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit. One bit is processed per cycle on
// unsigned magnitudes; the sign is fixed up in a single SIGN cycle, after
// which HI/LO are loaded and done pulses. HI/LO keep their old values while
// the operation runs; partial results live only in r_wh/r_wl.
//
// Handshake: start is taken only when the unit is idle (busy=0); a start seen
// while busy is dropped, never queued. busy rises the cycle after the accepting
// edge and stays high until HI/LO are loaded; done is high for exactly the one
// cycle after that load, and a new start may be accepted in that cycle.
module mult_div_unit #(
    parameter int DATA_WIDTH = mult_div_unit_pkg::DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = mult_div_unit_pkg::CNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [DATA_WIDTH-1:0]     busA,
    input  logic [DATA_WIDTH-1:0]     busB,
    input  logic                      hi_wr,
    input  logic                      lo_wr,
    input  logic [DATA_WIDTH-1:0]     busW,
    output logic [DATA_WIDTH-1:0]     hi,
    output logic [DATA_WIDTH-1:0]     lo,
    output logic                      busy,
    output logic                      done,
    output mult_div_unit_pkg::state_t o_dbg_state
);

    import mult_div_unit_pkg::*;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x,
                                                      input logic is_signed);
        return (is_signed && x[DATA_WIDTH-1]) ? -x : x;
    endfunction

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic [1:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_wh;
    logic [DATA_WIDTH-1:0]   r_wl;

    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_a_lat;
    logic [DATA_WIDTH-1:0]   w_b_lat;
    logic                    w_signed;
    logic                    w_div;
    logic [DATA_WIDTH-1:0]   w_mag_a;
    logic [DATA_WIDTH-1:0]   w_mag_b;
    logic                    w_sign_a;
    logic                    w_sign_b;
    logic                    w_neg_res;
    logic                    w_b_zero;

    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [DATA_WIDTH-1:0]   w_mul_wh_nxt;
    logic [DATA_WIDTH-1:0]   w_mul_wl_nxt;
    logic [DATA_WIDTH:0]     w_div_shift;
    logic [DATA_WIDTH:0]     w_div_diff;
    logic                    w_div_ge;
    logic [DATA_WIDTH-1:0]   w_div_wh_nxt;
    logic [DATA_WIDTH-1:0]   w_div_wl_nxt;

    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [DATA_WIDTH-1:0]   w_hi_res;
    logic [DATA_WIDTH-1:0]   w_lo_res;
    logic                    w_sign_load;
    logic                    w_idle_wr;
    logic                    w_hi_en;
    logic                    w_lo_en;
    logic [DATA_WIDTH-1:0]   w_hi_d;
    logic [DATA_WIDTH-1:0]   w_lo_d;

    assign w_accept = (r_state == ST_IDLE) && start;

    // Raw operands are kept: divide-by-zero returns the dividend unchanged.
    dffr_32 #(.WIDTH(DATA_WIDTH)) u_a_lat (
        .i_clk (clk), .i_rst (rst), .i_en (w_accept), .i_d (busA), .o_q (w_a_lat)
    );
    dffr_32 #(.WIDTH(DATA_WIDTH)) u_b_lat (
        .i_clk (clk), .i_rst (rst), .i_en (w_accept), .i_d (busB), .o_q (w_b_lat)
    );

    assign w_signed  = r_op[0];
    assign w_div     = r_op[1];
    assign w_mag_a   = abs_val(w_a_lat, w_signed);
    assign w_mag_b   = abs_val(w_b_lat, w_signed);
    assign w_sign_a  = w_signed && w_a_lat[DATA_WIDTH-1];
    assign w_sign_b  = w_signed && w_b_lat[DATA_WIDTH-1];
    assign w_neg_res = w_sign_a ^ w_sign_b;
    assign w_b_zero  = (w_b_lat == '0);

    // Multiply step: {r_wh,r_wl} is the product register, multiplier in r_wl.
    assign w_mul_sum    = {1'b0, r_wh} + (r_wl[0] ? {1'b0, w_mag_a} : '0);
    assign w_mul_wh_nxt = w_mul_sum[DATA_WIDTH:1];
    assign w_mul_wl_nxt = {w_mul_sum[0], r_wl[DATA_WIDTH-1:1]};

    // Restoring divide step: r_wh is the partial remainder, r_wl the dividend
    // shifting out on top while quotient bits shift in at the bottom.
    assign w_div_shift  = {r_wh, r_wl[DATA_WIDTH-1]};
    assign w_div_ge     = (w_div_shift >= {1'b0, w_mag_b});
    assign w_div_diff   = w_div_shift - {1'b0, w_mag_b};
    assign w_div_wh_nxt = w_div_ge ? w_div_diff[DATA_WIDTH-1:0] : w_div_shift[DATA_WIDTH-1:0];
    assign w_div_wl_nxt = {r_wl[DATA_WIDTH-2:0], w_div_ge};

    assign w_prod = {r_wh, r_wl};

    // Sign fix-up of the finished magnitude result; divide-by-zero overrides.
    always_comb begin
        w_hi_res = r_wh;
        w_lo_res = r_wl;
        if (!w_div) begin
            {w_hi_res, w_lo_res} = w_neg_res ? -w_prod : w_prod;
        end else if (w_b_zero) begin
            w_hi_res = w_a_lat;
            w_lo_res = '1;
        end else begin
            w_lo_res = w_neg_res ? -r_wl : r_wl;
            w_hi_res = w_sign_a ? -r_wh : r_wh;
        end
    end

    // mthi/mtlo only land when idle and no start is taken in the same cycle.
    assign w_sign_load = (r_state == ST_SIGN);
    assign w_idle_wr   = (r_state == ST_IDLE) && !start;
    assign w_hi_en     = w_sign_load || (w_idle_wr && hi_wr);
    assign w_lo_en     = w_sign_load || (w_idle_wr && lo_wr);
    assign w_hi_d      = w_sign_load ? w_hi_res : busW;
    assign w_lo_d      = w_sign_load ? w_lo_res : busW;

    dffr_32 #(.WIDTH(DATA_WIDTH)) u_hi (
        .i_clk (clk), .i_rst (rst), .i_en (w_hi_en), .i_d (w_hi_d), .o_q (hi)
    );
    dffr_32 #(.WIDTH(DATA_WIDTH)) u_lo (
        .i_clk (clk), .i_rst (rst), .i_en (w_lo_en), .i_d (w_lo_d), .o_q (lo)
    );

    // Control FSM with iteration counter and registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_op    <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CALC;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_op    <= op;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_SIGN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SIGN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Working registers: seeded with magnitudes at accept, stepped in CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wh <= '0;
            r_wl <= '0;
        end else if (w_accept) begin
            r_wh <= '0;
            r_wl <= op[1] ? abs_val(busA, op[0]) : abs_val(busB, op[0]);
        end else if (r_state == ST_CALC) begin
            r_wh <= w_div ? w_div_wh_nxt : w_mul_wh_nxt;
            r_wl <= w_div ? w_div_wl_nxt : w_mul_wl_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: table of known vectors, hand-written corner
// sequences (busy-time writes, idle writes, reset mid-operation) and random
// operations checked against a behavioural reference model via a queue.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] busA = '0;
  logic [W-1:0] busB = '0;
  logic         hi_wr = 1'b0;
  logic         lo_wr = 1'b0;
  logic [W-1:0] busW = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  state_t       dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } vec_t;

  vec_t vecs[7];

  mult_div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .busA        (busA),
    .busB        (busB),
    .hi_wr       (hi_wr),
    .lo_wr       (lo_wr),
    .busW        (busW),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    sa = a;
    sb = b;
    case (o)
      OP_MULTU: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
      OP_MULT:  return {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      OP_DIVU: begin
        if (b == '0) return {a, {W{1'b1}}};
        q = a / b;
        r = a % b;
        return {r, q};
      end
      default: begin
        if (b == '0) return {a, {W{1'b1}}};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // driver: present an operation for one cycle, push its expected result
  task automatic do_start(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp);
    @(negedge clk);
    op = o;
    busA = a;
    busB = b;
    start = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    busA = $urandom;
    busB = $urandom;
    op = 2'($urandom_range(0, 3));
  endtask

  // monitor: wait for done (bounded), check latency, busy span, hold, result
  task automatic wait_done(input string name, input bit inject);
    int n;
    int busy_cnt;
    bit seen;
    logic [2*W-1:0] pre;
    logic [2*W-1:0] exp;
    n = 0;
    busy_cnt = 0;
    seen = 1'b0;
    pre = {hi, lo};
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (inject && n == 1) begin
        start = 1'b1;
        busA = 32'd9;
        busB = 32'd9;
        hi_wr = 1'b1;
        busW = 32'hDEAD_BEEF;
      end
      if (inject && n == 2) begin
        start = 1'b0;
        hi_wr = 1'b0;
      end
      if (busy) busy_cnt++;
      if (n == 17) check({name, "_hold"}, {hi, lo}, pre);
      if (done) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(n), 64'd34);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_queue: got empty expected entry", name);
    end else begin
      exp = exp_q.pop_front();
      if (seen) check({name, "_result"}, {hi, lo}, exp);
    end
    @(negedge clk);
    check({name, "_done_pulse"}, {63'b0, done}, 64'd0);
    check({name, "_idle_after"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    int pulses;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{"multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{"mult_neg",   OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{"div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_100_7", OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[4] = '{"divu_by0",   OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
    vecs[5] = '{"div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{"div_by0",    OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

    // reset
    #2;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_flags", {62'b0, busy, done}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_hilo", {hi, lo}, 64'd0);

    // table vectors
    for (int i = 0; i < 7; i++) begin
      do_start(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].ehi, vecs[i].elo});
      wait_done(vecs[i].name, 1'b0);
    end

    // start/hi_wr while busy are ignored, operands were latched
    do_start(OP_MULTU, 32'd3, 32'd5, {32'd0, 32'd15});
    wait_done("busy_ignore", 1'b1);

    // mthi in idle
    @(negedge clk);
    hi_wr = 1'b1;
    busW = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_wr = 1'b0;
    check("idle_mthi", {hi, lo}, {32'hDEAD_BEEF, 32'd15});

    // mthi+mtlo together
    hi_wr = 1'b1;
    lo_wr = 1'b1;
    busW = 32'h1234_5678;
    @(negedge clk);
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    check("idle_both", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

    // mthi in the same cycle as an accepted start is dropped
    start = 1'b1;
    op = OP_MULTU;
    busA = 32'd2;
    busB = 32'd3;
    hi_wr = 1'b1;
    busW = 32'hFFFF_0000;
    exp_q.push_back({32'd0, 32'd6});
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_wr = 1'b0;
    check("start_wr_drop", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
    wait_done("mul_2_3", 1'b0);

    // reset mid-operation
    @(negedge clk);
    hi_wr = 1'b1;
    lo_wr = 1'b1;
    busW = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    do_start(OP_DIVU, 32'd1000, 32'd3, ref_model(OP_DIVU, 32'd1000, 32'd3));
    repeat (10) @(negedge clk);
    check("mid_busy", {63'b0, busy}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'd0);
    check("async_rst_busy", {63'b0, busy}, 64'd0);
    check("async_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_no_done", 64'(pulses), 64'd0);
    do_start(OP_MULTU, 32'd6, 32'd7, {32'd0, 32'd42});
    wait_done("after_rst", 1'b0);

    // random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i == 3) rb = 32'd1;
      if (i == 5) ra = 32'd0;
      do_start(ro, ra, rb, ref_model(ro, ra, rb));
      wait_done("random", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
